// File: rtl/fifo_readout_arb_pkg.sv
// fifo_readout_arb_pkg: shared FSM state type and default sizing for the readout arbiter
package fifo_readout_arb_pkg;
  localparam int DEF_NUM_BLOCKS = 12;
  localparam int DEF_WORD_BITS = 64;
  localparam int DEF_LAT = 2;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_SHIFT} state_t;
endpackage

// File: rtl/fifo_readout_arb_rr_pick.sv
// rr_pick: combinational round-robin pick, first requester after the last grant
module rr_pick
  import fifo_readout_arb_pkg::*;
#(
  parameter int N = DEF_NUM_BLOCKS
)(
  input  logic [N:1] i_req,
  input  logic [3:0] i_last,
  output logic [N:1] o_gnt,
  output logic       o_valid
);
  localparam int IW = $clog2(N + 1);
  logic [IW-1:0] w_idx;
  // walk from lowest to highest priority so the closest requester after i_last wins
  always_comb begin
    o_gnt = '0;
    o_valid = 1'b0;
    w_idx = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = IW'((int'(i_last) + k - 1) % N + 1);
      if (i_req[w_idx]) begin
        o_gnt = '0;
        o_gnt[w_idx] = 1'b1;
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_readout_arb.sv
// fifo_readout_arb: round-robin serial readout of block FIFOs into a held word
module fifo_readout_arb
  import fifo_readout_arb_pkg::*;
#(
  parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
  parameter int WORD_BITS = DEF_WORD_BITS,
  parameter int LAT = DEF_LAT
)(
  input  logic                  fifo_clk,
  input  logic                  fifo_rst,
  input  logic [NUM_BLOCKS:1]   fifo_empty,
  output logic [NUM_BLOCKS:1]   fifo_req,
  input  logic                  fifo_bit,
  input  logic [NUM_BLOCKS:1]   block_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_BITS-1:0]  out_data,
  output logic [3:0]            out_src
);
  localparam int BCW = $clog2(WORD_BITS) + 1;
  state_t r_state;
  logic [NUM_BLOCKS:1] r_req, w_cand, w_gnt;
  logic [3:0] r_last, r_src, r_wcnt, w_gidx;
  logic [BCW-1:0] r_bcnt;
  logic [WORD_BITS-2:0] r_shift;
  logic [WORD_BITS-1:0] r_data, w_word;
  logic r_valid, w_vld, w_free;
  assign w_cand = block_en & ~fifo_empty;
  assign w_free = !r_valid || out_ready;
  assign w_word = {r_shift, fifo_bit};
  assign fifo_req = r_req;
  assign out_valid = r_valid;
  assign out_data = r_data;
  assign out_src = r_src;
  rr_pick #(.N(NUM_BLOCKS)) u_pick (
    .i_req(w_cand),
    .i_last(r_last),
    .o_gnt(w_gnt),
    .o_valid(w_vld)
  );
  // one-hot grant to block index
  always_comb begin
    w_gidx = '0;
    for (int i = 1; i <= NUM_BLOCKS; i++) w_gidx = w_gnt[i] ? 4'(i) : w_gidx;
  end
  // transfer FSM: grant, pulse request, wait out the read latency, shift the word in, hold it
  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      r_state <= S_IDLE;
      r_req <= '0;
      r_valid <= 1'b0;
      r_data <= '0;
      r_src <= '0;
      r_last <= 4'(NUM_BLOCKS);
      r_bcnt <= '0;
      r_wcnt <= '0;
      r_shift <= '0;
    end else begin
      r_req <= '0;
      if (r_valid && out_ready) r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_vld && w_free) begin
          r_state <= S_REQ;
          r_req <= w_gnt;
          r_last <= w_gidx;
        end
        S_REQ: begin
          r_state <= (LAT == 1) ? S_SHIFT : S_WAIT;
          r_wcnt <= '0;
          r_bcnt <= '0;
        end
        S_WAIT: begin
          r_state <= (r_wcnt == 4'(LAT - 2)) ? S_SHIFT : S_WAIT;
          r_wcnt <= r_wcnt + 4'd1;
        end
        S_SHIFT: begin
          r_shift <= w_word[WORD_BITS-2:0];
          r_bcnt <= r_bcnt + 1'b1;
          if (r_bcnt == BCW'(WORD_BITS - 1)) begin
            r_state <= S_IDLE;
            r_valid <= 1'b1;
            r_data <= w_word;
            r_src <= r_last;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_readout_arb.sv
// tb_fifo_readout_arb: directed vector bench for the FIFO readout arbiter
module tb_fifo_readout_arb;
  localparam int N = 12;
  localparam int WB = 64;
  localparam int LT = 2;
  localparam int WB2 = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N:1] a_empty = '1, a_req, a_en = '1, b_empty = '1, b_req, b_en = '1;
  logic a_bit, b_bit, a_valid, b_valid;
  logic a_ready = 1'b0, b_ready = 1'b0;
  logic [WB-1:0] a_data, drv_w;
  logic [WB2-1:0] b_data;
  logic [WB2-1:0] b_byte = 8'hA5;
  logic [3:0] a_src, b_src;
  int checks = 0, errors = 0, cyc = 0, a_multi = 0, b_multi = 0, a_dis = 0;
  int ta = -1000, ga = 1, tb = -1000;

  typedef struct {
    logic [N:1] en;
    logic [N:1] full;
    int src;
  } vec_t;
  vec_t vt[8];

  fifo_readout_arb u_a (
    .fifo_clk(clk), .fifo_rst(rst), .fifo_empty(a_empty), .fifo_req(a_req),
    .fifo_bit(a_bit), .block_en(a_en), .out_valid(a_valid), .out_ready(a_ready),
    .out_data(a_data), .out_src(a_src)
  );
  fifo_readout_arb #(.NUM_BLOCKS(N), .WORD_BITS(WB2), .LAT(1)) u_b (
    .fifo_clk(clk), .fifo_rst(rst), .fifo_empty(b_empty), .fifo_req(b_req),
    .fifo_bit(b_bit), .block_en(b_en), .out_valid(b_valid), .out_ready(b_ready),
    .out_data(b_data), .out_src(b_src)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WB-1:0] word_of(input int g);
    return 64'hDEADBEEF01234567 + 64'(g - 3) * 64'h0101010101010101;
  endfunction

  // block FIFO model: after a request, serve that block's word MSB first from LAT cycles later
  initial begin
    a_bit = 1'b0;
    b_bit = 1'b0;
    forever begin
      @(negedge clk);
      if (a_req != '0) begin
        ta = cyc;
        for (int i = 1; i <= N; i++) if (a_req[i]) ga = i;
        if (!$onehot(a_req)) a_multi++;
      end
      if (b_req != '0) begin
        tb = cyc;
        if (!$onehot(b_req)) b_multi++;
      end
      drv_w = word_of(ga);
      if (cyc - ta >= LT && cyc - ta < LT + WB) a_bit = drv_w[WB - 1 - (cyc - ta - LT)];
      else a_bit = 1'b0;
      if (cyc - tb >= 1 && cyc - tb < 1 + WB2) b_bit = b_byte[WB2 - 1 - (cyc - tb - 1)];
      else b_bit = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req(input bit use_b, input int lim, output int g, output int t, output bit ok);
    logic [N:1] r;
    ok = 1'b0;
    g = 0;
    t = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      r = use_b ? b_req : a_req;
      if (!use_b && (a_req & ~a_en) != '0) a_dis++;
      if (r != '0) begin
        ok = 1'b1;
        t = cyc;
        for (int j = 1; j <= N; j++) if (r[j]) g = j;
      end
    end
    if (!ok) chk("req_timeout", 0, 1);
  endtask

  task automatic wait_valid(input bit use_b, input int lim, output int t, output bit ok);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (!use_b && (a_req & ~a_en) != '0) a_dis++;
      if (use_b ? b_valid : a_valid) begin
        ok = 1'b1;
        t = cyc;
      end
    end
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, t, tv, tp, hold_err;
    bit ok;
    logic [WB-1:0] hd;
    logic [3:0] hs;
    vt[0] = '{12'hFFF, 12'h004, 3};
    vt[1] = '{12'hFFF, 12'h015, 5};
    vt[2] = '{12'hFFF, 12'h015, 1};
    vt[3] = '{12'hFFF, 12'h802, 2};
    vt[4] = '{12'h7FF, 12'h802, 2};
    vt[5] = '{12'hFFF, 12'h800, 12};
    vt[6] = '{12'h040, 12'hFFF, 7};
    vt[7] = '{12'hFFF, 12'h108, 9};
    repeat (3) @(negedge clk);
    chk("rst_req", a_req, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_data", a_data, 0);
    chk("rst_src", a_src, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_en = vt[i].en;
      a_empty = ~vt[i].full;
      a_ready = 1'b0;
      wait_req(0, 10, g, t, ok);
      a_empty = '1;
      a_en = ~vt[i].en;
      chk("tbl_grant", g, vt[i].src);
      wait_valid(0, 100, tv, ok);
      chk("tbl_latency", tv - t, LT + WB);
      chk("tbl_src", a_src, vt[i].src);
      chk("tbl_data", a_data, word_of(vt[i].src));
      a_ready = 1'b1;
      @(negedge clk);
      a_ready = 1'b0;
      chk("tbl_drop", a_valid, 0);
    end

    pulse_reset();
    a_en = '1;
    a_empty = '0;
    a_ready = 1'b1;
    tp = 0;
    for (int k = 0; k < 13; k++) begin
      wait_req(0, 80, g, t, ok);
      chk("rr_order", g, k % 12 + 1);
      if (k > 0) chk("rr_period", t - tp, LT + WB + 1);
      tp = t;
    end

    pulse_reset();
    a_en = 12'hFEF;
    a_empty = '0;
    a_ready = 1'b1;
    a_dis = 0;
    for (int k = 0; k < 6; k++) begin
      wait_req(0, 80, g, t, ok);
      chk("skip5_order", g, (k < 4) ? k + 1 : k + 2);
    end
    a_ready = 1'b0;
    wait_valid(0, 100, tv, ok);
    chk("hold_src", a_src, 7);
    chk("hold_data", a_data, word_of(7));
    hd = a_data;
    hs = a_src;
    hold_err = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (a_req != '0 || !a_valid || a_data !== hd || a_src !== hs) hold_err++;
    end
    chk("hold_stable", hold_err, 0);
    a_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_grant", a_req, 12'h080);
    chk("hold_release_valid", a_valid, 0);
    chk("skip5_never_req", a_dis, 0);

    pulse_reset();
    a_en = '1;
    a_empty = ~12'h040;
    a_ready = 1'b1;
    wait_req(0, 10, g, t, ok);
    chk("midrst_grant", g, 7);
    for (int k = 0; k < 60 && cyc < t + LT + 30; k++) @(negedge clk);
    rst = 1'b1;
    a_empty = '0;
    @(negedge clk);
    chk("midrst_req", a_req, 0);
    chk("midrst_valid", a_valid, 0);
    chk("midrst_src", a_src, 0);
    rst = 1'b0;
    wait_req(0, 10, g, t, ok);
    chk("midrst_next_grant", g, 1);
    wait_valid(0, 100, tv, ok);
    chk("midrst_next_latency", tv - t, LT + WB);
    chk("midrst_next_data", a_data, word_of(1));
    a_empty = '1;
    a_ready = 1'b1;

    @(negedge clk);
    b_empty = ~12'h800;
    wait_req(1, 10, g, t, ok);
    b_empty = '1;
    chk("lat1_grant", g, 12);
    wait_valid(1, 30, tv, ok);
    chk("lat1_latency", tv - t, 1 + WB2);
    chk("lat1_data", b_data, 8'hA5);
    chk("lat1_src", b_src, 12);
    chk("a_onehot", a_multi, 0);
    chk("b_onehot", b_multi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
